// File: rtl/avalon_polysynth.sv
// avalon_polysynth: multi-voice square-wave synthesiser on Avalon-MM with note auto-stop,
// end-of-note interrupt and a PWM mixer driving a single audio bit.
module avalon_polysynth #(
    parameter int CHANNELS = 4,
    parameter int ACC_W = 24,
    parameter int DUR_W = 16,
    parameter int TICK_DIV = 50000,
    localparam int ADDR_W = $clog2(4*CHANNELS+2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [31:0]         writedata,
    input  logic                write,
    input  logic                read,
    input  logic                chipselect,
    output logic [31:0]         readdata,
    output logic                irq,
    output logic [CHANNELS-1:0] chan_active,
    output logic                vib
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(3*CHANNELS+1);
    localparam int A_STAT = 4*CHANNELS;
    localparam int A_MASK = 4*CHANNELS+1;

    logic [TW-1:0]       tick_q, tick_d;
    logic [CHANNELS-1:0] act_q, act_d, stat_q, stat_d, mask_q, mask_d, expire;
    logic [1:0]          vol_q [CHANNELS];
    logic [1:0]          vol_d [CHANNELS];
    logic [ACC_W-1:0]    inc_q [CHANNELS];
    logic [ACC_W-1:0]    inc_d [CHANNELS];
    logic [ACC_W-1:0]    acc_q [CHANNELS];
    logic [ACC_W-1:0]    acc_d [CHANNELS];
    logic [DUR_W-1:0]    dur_q [CHANNELS];
    logic [DUR_W-1:0]    dur_d [CHANNELS];
    logic [DUR_W-1:0]    rem_q [CHANNELS];
    logic [DUR_W-1:0]    rem_d [CHANNELS];
    logic [SW-1:0]       sum_q, sum_d, pc_q, pc_d;
    logic                vib_q, vib_d, wr, rd, tick;
    logic [31:0]         rd_q, rd_d;
    logic                unused_ok;

    assign unused_ok = &{1'b0, writedata};

    always_comb begin
        wr = chipselect & write;
        rd = chipselect & read;
        tick = tick_q == TW'(TICK_DIV-1);
        tick_d = tick ? '0 : tick_q + 1'b1;
        stat_d = stat_q;
        mask_d = mask_q;
        sum_d = '0;
        rd_d = '0;
        expire = '0;
        if (wr && address == ADDR_W'(A_STAT)) stat_d = stat_q & ~writedata[CHANNELS-1:0];
        if (wr && address == ADDR_W'(A_MASK)) mask_d = writedata[CHANNELS-1:0];
        if (rd && address == ADDR_W'(A_STAT)) rd_d = 32'(stat_q);
        if (rd && address == ADDR_W'(A_MASK)) rd_d = 32'(mask_q);
        for (int n = 0; n < CHANNELS; n++) begin
            act_d[n] = act_q[n];
            vol_d[n] = vol_q[n];
            inc_d[n] = inc_q[n];
            dur_d[n] = dur_q[n];
            rem_d[n] = rem_q[n];
            acc_d[n] = act_q[n] ? acc_q[n] + inc_q[n] : '0;
            if (tick && act_q[n] && dur_q[n] != '0) begin
                rem_d[n] = rem_q[n] - 1'b1;
                if (rem_q[n] <= DUR_W'(1)) begin
                    expire[n] = 1'b1;
                    act_d[n] = 1'b0;
                    rem_d[n] = '0;
                    acc_d[n] = '0;
                end
            end
            // A CTRL write overrides a same-cycle expiry, so no IRQ is raised for it
            if (wr && address == ADDR_W'(4*n)) begin
                act_d[n] = writedata[0];
                vol_d[n] = writedata[2:1];
                rem_d[n] = writedata[0] ? dur_q[n] : rem_q[n];
                acc_d[n] = '0;
                expire[n] = 1'b0;
            end
            if (wr && address == ADDR_W'(4*n+1)) inc_d[n] = writedata[ACC_W-1:0];
            if (wr && address == ADDR_W'(4*n+2)) dur_d[n] = writedata[DUR_W-1:0];
            if (rd && address == ADDR_W'(4*n))   rd_d = {29'b0, vol_q[n], act_q[n]};
            if (rd && address == ADDR_W'(4*n+1)) rd_d = 32'(inc_q[n]);
            if (rd && address == ADDR_W'(4*n+2)) rd_d = 32'(dur_q[n]);
            if (rd && address == ADDR_W'(4*n+3)) rd_d = {16'(rem_q[n]), 15'b0, act_q[n]};
            sum_d = sum_d + ((act_q[n] & acc_q[n][ACC_W-1]) ? SW'(vol_q[n]) : SW'(0));
        end
        stat_d = stat_d | expire;
        pc_d = (pc_q == SW'(3*CHANNELS-1)) ? '0 : pc_q + 1'b1;
        vib_d = pc_q < sum_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            act_q <= '0;
            stat_q <= '0;
            mask_q <= '0;
            sum_q <= '0;
            pc_q <= '0;
            vib_q <= 1'b0;
            rd_q <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                vol_q[n] <= 2'b10;
                inc_q[n] <= '0;
                dur_q[n] <= '0;
                rem_q[n] <= '0;
                acc_q[n] <= '0;
            end
        end else begin
            tick_q <= tick_d;
            act_q <= act_d;
            stat_q <= stat_d;
            mask_q <= mask_d;
            sum_q <= sum_d;
            pc_q <= pc_d;
            vib_q <= vib_d;
            rd_q <= rd_d;
            for (int n = 0; n < CHANNELS; n++) begin
                vol_q[n] <= vol_d[n];
                inc_q[n] <= inc_d[n];
                dur_q[n] <= dur_d[n];
                rem_q[n] <= rem_d[n];
                acc_q[n] <= acc_d[n];
            end
        end
    end

    assign readdata = rd_q;
    assign irq = |(stat_q & mask_q);
    assign chan_active = act_q;
    assign vib = vib_q;
endmodule
